// File: rtl/vga_timing_pattern_gen_if.sv
// Video bus between the VGA timing/pattern generator and its consumers.
// The master side (the generator) drives sync, colour, data-enable,
// coordinates and the frame strobe; the slave side supplies the pattern
// select and the solid colour.
interface vga_timing_pattern_gen_if #(
    parameter int RGB_W = 1,
    parameter int X_W   = 10,
    parameter int Y_W   = 9
);
    logic [1:0]         mode;
    logic [3*RGB_W-1:0] color_in;
    logic               hsync;
    logic               vsync;
    logic [3*RGB_W-1:0] rgb;
    logic               de;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic               frame_start;

    modport master (
        input  mode,
        input  color_in,
        output hsync,
        output vsync,
        output rgb,
        output de,
        output pix_x,
        output pix_y,
        output frame_start
    );

    modport slave (
        output mode,
        output color_in,
        input  hsync,
        input  vsync,
        input  rgb,
        input  de,
        input  pix_x,
        input  pix_y,
        input  frame_start
    );
endinterface

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA timing generator and test-pattern source.
// The pixel rate is derived from clk with a clock-enable divider (CLK_DIV
// clks per pixel). All outputs are registered from the counter state, so
// they lag the counters by one clk and stay mutually aligned.
// Optional macro VGA_BORDER_EN: when defined, a 1-pixel white border
// overrides the pattern on the outer edge of the visible area.
module vga_timing_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 2,
    parameter int RGB_W      = 1,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    vga_timing_pattern_gen_if.master    vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int CW      = 3 * RGB_W;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic          HS_ON    = 1'(HSYNC_POL);
    localparam logic          VS_ON    = 1'(VSYNC_POL);

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_GRID  = 2'd3
    } pattern_e;

    if ((H_ACTIVE % 8) != 0) begin : g_bad_h_active
        $error("vga_timing_pattern_gen: H_ACTIVE must be a multiple of 8");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_pattern_gen: CLK_DIV must be at least 1");
    end

    logic [DW-1:0] div;
    logic          pe;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          frame_wrap;
    logic [BW-1:0] bar_pix;
    logic [2:0]    bar_idx;
    logic [2:0]    bar_color;
    pattern_e      mode_q;
    logic          wrap_q;

    logic          hs_act;
    logic          vs_act;
    logic          de_c;
    logic [CW-1:0] pat_rgb;

    assign pe         = (div == DIV_LAST);
    assign h_wrap     = (h_cnt == H_LAST);
    assign v_wrap     = (v_cnt == V_LAST);
    assign frame_wrap = pe && h_wrap && v_wrap;

    // Pixel-enable divider: counts 0..CLK_DIV-1, pe on the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (pe) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Raster counters, advanced once per pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pe) begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Bar tracker: bar_pix follows h_cnt mod BAR_W and bar_idx follows
    // h_cnt / BAR_W without a divider; both restart with each line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (pe) begin
            if (h_wrap) begin
                bar_pix <= '0;
                bar_idx <= '0;
            end else if (bar_pix == BAR_LAST) begin
                bar_pix <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_pix <= bar_pix + 1'b1;
            end
        end
    end

    // Frame boundary: latch the pattern select as the counters wrap to (0,0)
    // and delay the wrap one clk so frame_start lines up with the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
            mode_q <= PAT_SOLID;
        end else begin
            wrap_q <= frame_wrap;
            if (frame_wrap) begin
                mode_q <= pattern_e'(vga.mode);
            end
        end
    end

    assign hs_act    = (h_cnt >= HS_START) && (h_cnt <= HS_END);
    assign vs_act    = (v_cnt >= VS_START) && (v_cnt <= VS_END);
    assign de_c      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign bar_color = ~bar_idx;

`ifdef VGA_BORDER_EN
    localparam logic [HW-1:0] H_VIS_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_VIS_LAST = VW'(V_ACTIVE - 1);
    logic on_border;
    assign on_border = (h_cnt == '0) || (h_cnt == H_VIS_LAST) ||
                       (v_cnt == '0) || (v_cnt == V_VIS_LAST);
`endif

    // Pattern colour for the current counter position.
    always_comb begin
        pat_rgb = '0;
        case (mode_q)
            PAT_SOLID: pat_rgb = vga.color_in;
            PAT_BARS:  pat_rgb = {{RGB_W{bar_color[2]}},
                                  {RGB_W{bar_color[1]}},
                                  {RGB_W{bar_color[0]}}};
            PAT_CHECK: pat_rgb = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ?
                                 {CW{1'b1}} : {CW{1'b0}};
            PAT_GRID:  pat_rgb = ((h_cnt[3:0] == 4'd0) || (v_cnt[3:0] == 4'd0)) ?
                                 {CW{1'b1}} : {CW{1'b0}};
            default:   pat_rgb = '0;
        endcase
`ifdef VGA_BORDER_EN
        if (on_border) begin
            pat_rgb = {CW{1'b1}};
        end
`endif
    end

    // Output register stage: one clk behind the counters, blanking forces
    // rgb and coordinates to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga.hsync       <= ~HS_ON;
            vga.vsync       <= ~VS_ON;
            vga.rgb         <= '0;
            vga.de          <= 1'b0;
            vga.pix_x       <= '0;
            vga.pix_y       <= '0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.hsync       <= hs_act ? HS_ON : ~HS_ON;
            vga.vsync       <= vs_act ? VS_ON : ~VS_ON;
            vga.de          <= de_c;
            vga.rgb         <= de_c ? pat_rgb : '0;
            vga.pix_x       <= de_c ? XW'(h_cnt) : '0;
            vga.pix_y       <= de_c ? YW'(v_cnt) : '0;
            vga.frame_start <= wrap_q;
        end
    end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen with a reduced raster (40x20 total,
// 32x16 visible, 2 clks per pixel). A position-based reference model pushes
// the expected output word on every posedge; the word is popped and compared
// on the following negedge. Directed checks cover reset, timing, patterns,
// mid-frame mode change and asynchronous reset.
module tb_vga_timing_pattern_gen;

    localparam int H_ACTIVE   = 32;
    localparam int H_FP       = 2;
    localparam int H_SYNC     = 4;
    localparam int H_BP       = 2;
    localparam int V_ACTIVE   = 16;
    localparam int V_FP       = 1;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 1;
    localparam int CLK_DIV    = 2;
    localparam int RGB_W      = 1;
    localparam int HSYNC_POL  = 0;
    localparam int VSYNC_POL  = 0;
    localparam int CHECK_LOG2 = 2;

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_PIX = H_TOTAL * V_TOTAL;
    localparam int FRAME_CLK = FRAME_PIX * CLK_DIV;
    localparam int LIMIT     = 2 * FRAME_CLK + 100;
    localparam int XW        = $clog2(H_ACTIVE);
    localparam int YW        = $clog2(V_ACTIVE);
    localparam int CW        = 3 * RGB_W;
    localparam int OW        = 4 + XW + YW + CW;

    localparam logic HS_IDLE = (HSYNC_POL == 0);
    localparam logic VS_IDLE = (VSYNC_POL == 0);
    localparam logic [OW-1:0] RESET_VEC = {HS_IDLE, VS_IDLE, 1'b0, 1'b0,
                                           {XW{1'b0}}, {YW{1'b0}}, {CW{1'b0}}};
    localparam logic [CW-1:0] COLOR = 3'b101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_pattern_gen_if #(.RGB_W(RGB_W), .X_W(XW), .Y_W(YW)) vga ();

    vga_timing_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV), .RGB_W(RGB_W), .HSYNC_POL(HSYNC_POL),
        .VSYNC_POL(VSYNC_POL), .CHECK_LOG2(CHECK_LOG2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vga(vga)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] dut_vec();
        return {vga.hsync, vga.vsync, vga.de, vga.frame_start, vga.pix_x, vga.pix_y, vga.rgb};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return vga.hsync;
            1:       return vga.vsync;
            2:       return vga.de;
            default: return vga.frame_start;
        endcase
    endfunction

    // Reference model: k counts posedges since reset release; the counters
    // seen at posedge k have advanced floor((k-1)/CLK_DIV) pixels.
    logic [OW-1:0] sb_q[$];
    int unsigned   k = 0;
    logic [1:0]    m_mode = 2'd0;
    logic [1:0]    m_prev = 2'd0;

    always @(posedge clk) begin : scoreboard_model
        int unsigned p, h, v, bar;
        logic fs_e, de_e, hs_e, vs_e;
        logic [CW-1:0] rgb_e;
        logic [2:0] c;
        logic [XW-1:0] px;
        logic [YW-1:0] py;
        if (!rst_n) begin
            k = 0;
            m_mode = 2'd0;
            m_prev = 2'd0;
            sb_q.push_back(RESET_VEC);
        end else begin
            k++;
            p = (k - 1) / CLK_DIV;
            fs_e = (p > 0) && (p % FRAME_PIX == 0) && ((k - 1) % CLK_DIV == 0);
            if (fs_e) m_mode = m_prev;
            m_prev = vga.mode;
            h = p % H_TOTAL;
            v = (p / H_TOTAL) % V_TOTAL;
            de_e = (h < H_ACTIVE) && (v < V_ACTIVE);
            hs_e = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? !HS_IDLE : HS_IDLE;
            vs_e = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? !VS_IDLE : VS_IDLE;
            rgb_e = '0;
            if (de_e) begin
                case (m_mode)
                    2'd0: rgb_e = vga.color_in;
                    2'd1: begin
                        bar = h / (H_ACTIVE / 8);
                        c = 3'(7 - bar);
                        for (int ch = 0; ch < 3; ch++) rgb_e[ch*RGB_W +: RGB_W] = {RGB_W{c[ch]}};
                    end
                    2'd2: rgb_e = ((((h >> CHECK_LOG2) ^ (v >> CHECK_LOG2)) & 1) != 0) ? '1 : '0;
                    default: rgb_e = ((h % 16 == 0) || (v % 16 == 0)) ? '1 : '0;
                endcase
`ifdef VGA_BORDER_EN
                if (h == 0 || h == H_ACTIVE - 1 || v == 0 || v == V_ACTIVE - 1) rgb_e = '1;
`endif
            end
            px = de_e ? XW'(h) : '0;
            py = de_e ? YW'(v) : '0;
            sb_q.push_back({hs_e, vs_e, de_e, fs_e, px, py, rgb_e});
        end
    end

    always @(negedge clk) begin : scoreboard_check
        logic [OW-1:0] exp;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check_val("outputs", dut_vec(), exp);
        end
    end

    task automatic wait_fs(input string tag);
        bit seen = 0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            if (vga.frame_start) begin seen = 1; break; end
        end
        check_val({tag, "_fs_seen"}, seen, 1);
    endtask

    task automatic check_pix(input string tag, input int x, input int y, input logic [CW-1:0] exp);
        bit seen = 0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            if (vga.de && vga.pix_x == XW'(x) && vga.pix_y == YW'(y)) begin seen = 1; break; end
        end
        check_val({tag, "_seen"}, seen, 1);
        if (seen) check_val(tag, vga.rgb, exp);
    endtask

    // Clks from a reset release (made just after a negedge) to the first
    // sample showing frame_start: a full frame plus one register stage.
    task automatic fs_latency(input string tag);
        int cnt = 0;
        bit seen = 0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            cnt++;
            if (vga.frame_start) begin seen = 1; break; end
        end
        check_val({tag, "_seen"}, seen, 1);
        check_val(tag, cnt, FRAME_CLK + 1);
    endtask

    task automatic measure_run(input string tag, input int sel, input logic lvl,
                               input int exp_len, input int exp_per);
        bit found = 0;
        int len = 1;
        int per;
        logic prev, cur;
        prev = sig(sel);
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            cur = sig(sel);
            if (cur == lvl && prev != lvl) begin found = 1; break; end
            prev = cur;
        end
        check_val({tag, "_edge"}, found, 1);
        if (!found) return;
        found = 0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            cur = sig(sel);
            if (cur != lvl) begin found = 1; break; end
            len++;
        end
        check_val({tag, "_len"}, len, exp_len);
        if (exp_per > 0) begin
            per = len;
            prev = cur;
            found = 0;
            for (int i = 0; i < LIMIT; i++) begin
                @(negedge clk);
                per++;
                cur = sig(sel);
                if (cur == lvl && prev != lvl) begin found = 1; break; end
                prev = cur;
            end
            check_val({tag, "_period"}, per, exp_per);
        end
    endtask

    task automatic de_to_hsync(input string tag);
        bit found = 0;
        int cnt = 0;
        logic prev;
        prev = vga.de;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            if (vga.de && !prev) begin found = 1; break; end
            prev = vga.de;
        end
        check_val({tag, "_de_rise"}, found, 1);
        found = 0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            cnt++;
            if (vga.hsync == !HS_IDLE) begin found = 1; break; end
        end
        check_val(tag, cnt, CLK_DIV * (H_ACTIVE + H_FP));
    endtask

    task automatic de_per_frame(input string tag);
        int cnt = 0;
        bit found = 0;
        wait_fs({tag, "_start"});
        if (vga.de) cnt++;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            if (vga.frame_start) begin found = 1; break; end
            if (vga.de) cnt++;
        end
        check_val({tag, "_end_seen"}, found, 1);
        check_val(tag, cnt, H_ACTIVE * V_ACTIVE * CLK_DIV);
    endtask

    initial begin
        vga.mode     = 2'd0;
        vga.color_in = COLOR;
        rst_n        = 1'b0;
        repeat (10) @(negedge clk);
        check_val("rst_hsync", vga.hsync, HS_IDLE);
        check_val("rst_vsync", vga.vsync, VS_IDLE);
        check_val("rst_rgb", vga.rgb, 0);
        check_val("rst_de", vga.de, 0);
        check_val("rst_frame_start", vga.frame_start, 0);
        #1 rst_n = 1'b1;
        fs_latency("fs_after_release");

        measure_run("hsync", 0, !HS_IDLE, CLK_DIV * H_SYNC, CLK_DIV * H_TOTAL);
        measure_run("de_line", 2, 1'b1, CLK_DIV * H_ACTIVE, 0);
        de_to_hsync("de_to_hsync_fall");
        measure_run("vsync", 1, !VS_IDLE, CLK_DIV * H_TOTAL * V_SYNC, FRAME_CLK);
        measure_run("frame_start", 3, 1'b1, 1, FRAME_CLK);
        de_per_frame("de_clks_per_frame");
        check_pix("solid_10_3", 10, 3, COLOR);

        vga.mode = 2'd1;
        wait_fs("bars");
        check_pix("bar_1_2", 1, 2, 3'b111);
        check_pix("bar_3_2", 3, 2, 3'b111);
        check_pix("bar_4_2", 4, 2, 3'b110);
        check_pix("bar_28_2", 28, 2, 3'b000);
        check_pix("bar_30_2", 30, 2, 3'b000);

        vga.mode = 2'd0;
        wait_fs("solid");
        check_pix("solid_3_5", 3, 5, COLOR);
        vga.mode = 2'd2;
        check_pix("no_tear_10_7", 10, 7, COLOR);
        check_pix("no_tear_20_12", 20, 12, COLOR);
        wait_fs("checker");
        check_pix("check_1_1", 1, 1, 3'b000);
        check_pix("check_5_1", 5, 1, 3'b111);
        check_pix("check_5_5", 5, 5, 3'b000);

        vga.mode = 2'd3;
        wait_fs("grid");
        check_pix("grid_16_3", 16, 3, 3'b111);
        check_pix("grid_5_3", 5, 3, 3'b000);
        check_pix("grid_17_8", 17, 8, 3'b000);

        check_pix("pre_reset_20_10", 20, 10, 3'b000);
        #2 rst_n = 1'b0;
        #1 check_val("async_reset", dut_vec(), RESET_VEC);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        fs_latency("fs_after_midframe_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(20 * LIMIT * 10);
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
